uart_tx: RTL

8N1 UART transmitter, the outbound counterpart of the team's UART receiver: serializes one byte per `trmt` strobe onto `TX` as start bit, 8 data bits LSB-first, and stop bit. Bit period matches the receiver (2604 clk at 50 MHz, 19200 baud), so a `uart_tx`→receiver loopback is bit-exact. It sits between the command/response logic and the board serial pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/uart_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART transmitter and receiver.
//   BAUD_DIV_DFLT : clk cycles per bit (50 MHz / 19200 baud)
//   FRAME_BITS    : start + 8 data + stop
//   tx_state_t    : transmitter FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned BAUD_DIV_DFLT = 2604;
  localparam int unsigned FRAME_BITS    = 10;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO with count-based full/empty and combinational read data.
// A push while full is dropped unless a pop happens in the same cycle; a pop
// while empty is ignored.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   i_push, i_data   : write strobe and byte
//   i_pop            : read strobe (o_data is consumed)
//   o_data           : entry at the read pointer
//   o_full, o_empty  : occupancy flags
// DEPTH must be a power of 2, at least 2.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_wr_en;
  logic w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd_en = i_pop && !o_empty;
  // A pop in the same cycle frees the slot being written, so full is no block.
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each
// held BAUD_DIV clk cycles. Bit timing matches the team UART receiver.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   trmt       : one-cycle request to send tx_data
//   tx_data    : byte, sampled when trmt=1
//   TX         : serial line, idle high, registered
//   tx_done    : sticky frame-complete flag, cleared on next frame load
//   busy       : frame in progress
//   full       : input FIFO full (0 when the FIFO is not built)
// Parameters: BAUD_DIV (16..4095), FIFO_DEPTH (power of 2, >= 2).
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DFLT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       full
);

  if (BAUD_DIV < 16 || BAUD_DIV > 4095 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx: BAUD_DIV or FIFO_DEPTH out of range");
  end

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [8:0]  r_shift;
  logic [8:0]  w_shift_nxt;
  logic [11:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic        r_tx;
  logic        r_tx_done;
  logic        w_tx_nxt;

  logic        w_load;
  logic [7:0]  w_load_data;
  logic        w_fifo_empty;
  logic        w_baud_wrap;
  logic        w_frame_end;

  // -------------------------------------------------------------------------
  // Byte source
  // -------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
  logic [7:0] w_fifo_data;
  logic       w_fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (trmt),
    .i_data  (tx_data),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_load      = (r_state == IDLE) && !w_fifo_empty;
  assign w_load_data = w_fifo_data;
  assign full        = w_fifo_full;
`else
  // Requests arriving while a frame is in progress are simply dropped.
  assign w_load       = (r_state == IDLE) && trmt;
  assign w_load_data  = tx_data;
  assign w_fifo_empty = 1'b1;
  assign full         = 1'b0;
`endif

  assign w_baud_wrap = (r_baud_cnt == 12'(BAUD_DIV - 1));
  // The tenth bit period (stop bit) ends on this cycle.
  assign w_frame_end = (r_state == TRANSMIT) && w_baud_wrap &&
                       (r_bit_cnt == 4'(FRAME_BITS - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: each combinational output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_load)      w_state_nxt = TRANSMIT;
      TRANSMIT: if (w_frame_end) w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (TX next value is registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    busy        = (r_state == TRANSMIT);
    w_shift_nxt = r_shift;
    if (w_load) begin
      w_shift_nxt = {w_load_data, 1'b0};
    end else if (r_state == TRANSMIT && w_baud_wrap) begin
      w_shift_nxt = {1'b1, r_shift[8:1]};
    end
    // Registering TX from next-state values puts the start bit on the line
    // in the same cycle busy rises.
    w_tx_nxt = 1'b1;
    if (w_state_nxt == TRANSMIT) w_tx_nxt = w_shift_nxt[0];
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_load) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
        r_tx_done  <= 1'b0;
      end else if (r_state == TRANSMIT) begin
        if (w_baud_wrap) begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= r_bit_cnt + 1'b1;
        end else begin
          r_baud_cnt <= r_baud_cnt + 1'b1;
        end
        // With a FIFO, done only flags the end of the last queued frame.
        if (w_frame_end && w_fifo_empty) r_tx_done <= 1'b1;
      end
    end
  end

  assign TX      = r_tx;
  assign tx_done = r_tx_done;

endmodule : uart_tx
